spio_uart_pkt_tx: RTL and testbench

Parametrised packet serialiser for the spio UART link: accepts 40- or 72-bit SpiNNaker packets on a valid/ready stream and shifts them out as 8-bit asynchronous frames (LSB first) at a fixed baud period. It honours the peer's CTS at packet boundaries and discards packets with bad parity. It also emits a line-break synchronisation pattern on request. It sits between the spio TX packet stream and the TX pin, in the same clock domain as `spio_uart`.

---
 rtl/spio_uart_pkt_tx.sv | 176 +++++++++++++++++
 tb/tb_spio_uart_pkt_tx.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spio_uart_pkt_tx.sv
// rtl/spio_uart_pkt_tx.sv - spio packet serialiser: 40/72-bit packets to 8N1-style UART frames with CTS and sync break
module spio_uart_pkt_tx #(
    parameter int BAUD_PERIOD   = 325,
    parameter int BAUD_NUM_BITS = 9,
    parameter int NUM_STOP_BITS = 1,
    parameter int CHECK_PARITY  = 1,
    parameter int BREAK_BITS    = 20
) (
    input  logic        CLK_IN,
    input  logic        RESET_IN,
    input  logic [71:0] TX_DATA_IN,
    input  logic        TX_VLD_IN,
    output logic        TX_RDY_OUT,
    output logic        TX_PACKET_DROPPED_OUT,
    input  logic        CTS_IN,
    output logic        TX_OUT,
    input  logic        SYNC_TRIGGER_IN,
    output logic        SYNCHRONISING_OUT
);

    localparam int BRK_W = (BREAK_BITS > 1) ? $clog2(BREAK_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CTS,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t                   state, state_n;
    logic [BAUD_NUM_BITS-1:0] baud_cnt, baud_n;
    logic [2:0]               bit_cnt, bit_n;
    logic [1:0]               stop_cnt, stop_n;
    logic [3:0]               byte_cnt, byte_n;
    logic [BRK_W-1:0]         brk_cnt, brk_n;
    logic [71:0]              shift, shift_n;
    logic                     has_pkt, has_pkt_n;
    logic                     pending, pending_n;
    logic                     rdy, rdy_n;
    logic                     drop, drop_n;
    logic                     tx, tx_n;

    logic transfer;
    logic bit_done;
    logic sync_req;
    logic parity_ok;
    logic accept;

    assign transfer  = TX_VLD_IN && rdy;
    assign bit_done  = (baud_cnt == BAUD_NUM_BITS'(BAUD_PERIOD - 1));
    assign sync_req  = pending || SYNC_TRIGGER_IN;
    // Odd parity over the bits actually sent: 72 for long packets, 40 for short.
    assign parity_ok = TX_DATA_IN[1] ? (^TX_DATA_IN) : (^TX_DATA_IN[39:0]);
    assign accept    = (CHECK_PARITY == 0) || parity_ok;

    always_comb begin
        state_n   = state;
        bit_n     = bit_cnt;
        stop_n    = stop_cnt;
        byte_n    = byte_cnt;
        brk_n     = brk_cnt;
        shift_n   = shift;
        has_pkt_n = has_pkt;
        pending_n = sync_req;
        drop_n    = 1'b0;

        case (state)
            IDLE: begin
                if (transfer) begin
                    if (accept) begin
                        shift_n   = TX_DATA_IN;
                        byte_n    = TX_DATA_IN[1] ? 4'd9 : 4'd5;
                        has_pkt_n = 1'b1;
                        state_n   = WAIT_CTS;
                    end else begin
                        drop_n = 1'b1;
                    end
                end
                if (sync_req) state_n = BREAK;
            end
            WAIT_CTS: begin
                if (sync_req)    state_n = BREAK;
                else if (CTS_IN) state_n = START;
            end
            START: begin
                bit_n = 3'd0;
                if (bit_done) state_n = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    shift_n = {1'b0, shift[71:1]};
                    bit_n   = bit_cnt + 3'd1;
                    stop_n  = 2'd0;
                    if (bit_cnt == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (stop_cnt == 2'(NUM_STOP_BITS - 1)) begin
                        if (byte_cnt == 4'd1) begin
                            has_pkt_n = 1'b0;
                            state_n   = sync_req ? BREAK : IDLE;
                        end else begin
                            byte_n  = byte_cnt - 4'd1;
                            state_n = START;
                        end
                    end else begin
                        stop_n = stop_cnt + 2'd1;
                    end
                end
            end
            BREAK: begin
                if (bit_done) begin
                    if (brk_cnt == BRK_W'(BREAK_BITS - 1)) begin
                        pending_n = 1'b0;
                        state_n   = has_pkt ? WAIT_CTS : IDLE;
                    end else begin
                        brk_n = brk_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (state_n == BREAK && state != BREAK) brk_n = '0;

        // Restarting on every state change keeps bit phase independent of history.
        baud_n = (state_n != state || bit_done) ? '0 : baud_cnt + 1'b1;

        case (state)
            START, BREAK: tx_n = 1'b0;
            DATA:         tx_n = shift[0];
            default:      tx_n = 1'b1;
        endcase

        rdy_n = (state == IDLE) && (state_n == IDLE) && !pending_n;
    end

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            stop_cnt <= 2'd0;
            byte_cnt <= 4'd0;
            brk_cnt  <= '0;
            shift    <= '0;
            has_pkt  <= 1'b0;
            pending  <= 1'b0;
            rdy      <= 1'b0;
            drop     <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            stop_cnt <= stop_n;
            byte_cnt <= byte_n;
            brk_cnt  <= brk_n;
            shift    <= shift_n;
            has_pkt  <= has_pkt_n;
            pending  <= pending_n;
            rdy      <= rdy_n;
            drop     <= drop_n;
            tx       <= tx_n;
        end
    end

    assign TX_RDY_OUT            = rdy;
    assign TX_PACKET_DROPPED_OUT = drop;
    assign TX_OUT                = tx;
    assign SYNCHRONISING_OUT     = pending;

endmodule

// File: tb/tb_spio_uart_pkt_tx.sv
// tb/tb_spio_uart_pkt_tx.sv - directed bench for spio_uart_pkt_tx (BAUD_PERIOD=4, 1 stop bit, 3-bit break)
module tb_spio_uart_pkt_tx;

    localparam int P    = 4;
    localparam int BYTE = 10 * P;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [71:0] data = '0;
    logic        vld = 1'b0, vld_np = 1'b0, cts = 1'b1, sync = 1'b0;
    logic        rdy, drop, tx, so;
    logic        rdy_np, drop_np, tx_np, so_np;

    int tests_run = 0;
    int tests_failed = 0;

    logic tx_log [1024];
    logic rdy_log [1024];
    logic drop_log [1024];
    logic so_log [1024];
    logic txnp_log [1024];
    logic dropnp_log [1024];
    int   cap_n = 0;

    always #5 clk = ~clk;

    spio_uart_pkt_tx #(.BAUD_PERIOD(P), .BAUD_NUM_BITS(2), .NUM_STOP_BITS(1),
                       .CHECK_PARITY(1), .BREAK_BITS(3)) dut (
        .CLK_IN(clk), .RESET_IN(rst), .TX_DATA_IN(data), .TX_VLD_IN(vld),
        .TX_RDY_OUT(rdy), .TX_PACKET_DROPPED_OUT(drop), .CTS_IN(cts),
        .TX_OUT(tx), .SYNC_TRIGGER_IN(sync), .SYNCHRONISING_OUT(so));

    spio_uart_pkt_tx #(.BAUD_PERIOD(P), .BAUD_NUM_BITS(2), .NUM_STOP_BITS(1),
                       .CHECK_PARITY(0), .BREAK_BITS(3)) dut_np (
        .CLK_IN(clk), .RESET_IN(rst), .TX_DATA_IN(data), .TX_VLD_IN(vld_np),
        .TX_RDY_OUT(rdy_np), .TX_PACKET_DROPPED_OUT(drop_np), .CTS_IN(cts),
        .TX_OUT(tx_np), .SYNC_TRIGGER_IN(sync), .SYNCHRONISING_OUT(so_np));

    // Log index k holds outputs seen after the k-th rising edge following the transfer.
    task automatic capture(input int n, input int cts_rise, input int cts_fall,
                           input int s_a, input int s_b);
        cap_n = n;
        for (int i = 0; i < n; i++) begin
            tx_log[i]     = tx;
            rdy_log[i]    = rdy;
            drop_log[i]   = drop;
            so_log[i]     = so;
            txnp_log[i]   = tx_np;
            dropnp_log[i] = drop_np;
            if (i == cts_rise) cts = 1'b1;
            if (i == cts_fall) cts = 1'b0;
            sync = (i == s_a) || (i == s_b);
            @(negedge clk);
        end
        sync = 1'b0;
    endtask

    task automatic send(input logic [71:0] d, input bit np, input bit with_sync);
        data = d;
        if (np) vld_np = 1'b1;
        else    vld    = 1'b1;
        sync = with_sync;
        @(negedge clk);
        vld = 1'b0; vld_np = 1'b0; sync = 1'b0;
    endtask

    function automatic int first_zero(input int from);
        for (int i = from; i < cap_n; i++) if (tx_log[i] === 1'b0) return i;
        return -1;
    endfunction

    function automatic int low_run(input int from);
        int c = 0;
        for (int i = from; i < cap_n && tx_log[i] === 1'b0; i++) c++;
        return c;
    endfunction

    function automatic int count_tx_low(input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) if (tx_log[i] !== 1'b1) c++;
        return c;
    endfunction

    function automatic int count_rdy_high(input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) if (rdy_log[i] === 1'b1) c++;
        return c;
    endfunction

    // Rebuilds bytes from the line: start low, 8 data bits each held P cycles, stop high.
    task automatic decode(input int s, input int nbytes, output logic [71:0] val, output int bad);
        val = '0;
        bad = (s < 0 || s + nbytes * BYTE > cap_n) ? 1 : 0;
        if (bad == 0) begin
            for (int b = 0; b < nbytes; b++) begin
                for (int c = 0; c < BYTE; c++) begin
                    logic lvl;
                    int   k;
                    k = c / P;
                    if (k == 0)      lvl = 1'b0;
                    else if (k == 9) lvl = 1'b1;
                    else             lvl = tx_log[s + b * BYTE + k * P];
                    if (tx_log[s + b * BYTE + c] !== lvl) bad++;
                    if (k >= 1 && k <= 8) val[b * 8 + k - 1] = lvl;
                end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        tests_run++;
        if ({tx, rdy, drop, so} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got tx/rdy/drop/sync=%b want 1000", {tx, rdy, drop, so});
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (rdy !== 1'b1) begin tests_failed++; $display("FAIL reset_rdy_rise: got %b want 1", rdy); end
    endtask

    task automatic test_short();
        logic [71:0] v; int bad; int fz;
        tests_run++;
        if (rdy !== 1'b1) begin tests_failed++; $display("FAIL short_rdy_before: got %b want 1", rdy); end
        send(72'h00_0000_0100, 0, 0);
        capture(215, -1, -1, -1, -1);
        fz = first_zero(0);
        tests_run++;
        if (fz !== 2) begin tests_failed++; $display("FAIL short_latency: got %0d want 2", fz); end
        decode(2, 5, v, bad);
        tests_run++;
        if (bad !== 0 || v[39:0] !== 40'h00_0000_0100) begin
            tests_failed++; $display("FAIL short_data: got %h (framing errs %0d) want 0000000100", v[39:0], bad);
        end
        tests_run++;
        if (count_tx_low(202, 214) !== 0) begin
            tests_failed++; $display("FAIL short_idle_after: got %0d low cycles want 0", count_tx_low(202, 214));
        end
        tests_run++;
        if (count_rdy_high(0, 201) !== 0 || rdy_log[202] !== 1'b1) begin
            tests_failed++; $display("FAIL short_rdy: got %0d busy-high, rdy[202]=%b want 0,1", count_rdy_high(0, 201), rdy_log[202]);
        end
    endtask

    task automatic test_long();
        logic [71:0] v; int bad;
        send(72'h0000_0005_0000_0005_02, 0, 0);
        capture(375, -1, -1, -1, -1);
        decode(2, 9, v, bad);
        tests_run++;
        if (bad !== 0 || v !== 72'h0000_0005_0000_0005_02) begin
            tests_failed++; $display("FAIL long_data: got %h (framing errs %0d) want 000000050000000502", v, bad);
        end
        tests_run++;
        if (count_rdy_high(0, 361) !== 0 || rdy_log[362] !== 1'b1) begin
            tests_failed++; $display("FAIL long_rdy: got %0d busy-high, rdy[362]=%b want 0,1", count_rdy_high(0, 361), rdy_log[362]);
        end
        tests_run++;
        if (count_tx_low(362, 374) !== 0) begin
            tests_failed++; $display("FAIL long_end: got %0d low cycles after packet want 0", count_tx_low(362, 374));
        end
    endtask

    task automatic test_bad_parity();
        logic [71:0] v; int bad; int pulses; int np_drops;
        send(72'h00_0000_0101, 0, 0);
        capture(30, -1, -1, -1, -1);
        pulses = 0;
        for (int i = 0; i < 30; i++) if (drop_log[i] === 1'b1) pulses++;
        tests_run++;
        if (count_tx_low(0, 29) !== 0) begin
            tests_failed++; $display("FAIL drop_line_idle: got %0d low cycles want 0", count_tx_low(0, 29));
        end
        tests_run++;
        if (drop_log[0] !== 1'b1 || pulses !== 1) begin
            tests_failed++; $display("FAIL drop_pulse: got first=%b count=%0d want 1,1", drop_log[0], pulses);
        end
        tests_run++;
        if (count_rdy_high(0, 29) !== 30) begin
            tests_failed++; $display("FAIL drop_rdy: got %0d high cycles want 30", count_rdy_high(0, 29));
        end
        tests_run++;
        if (rdy_np !== 1'b1) begin tests_failed++; $display("FAIL np_rdy_before: got %b want 1", rdy_np); end
        send(72'h00_0000_0101, 1, 0);
        capture(210, -1, -1, -1, -1);
        np_drops = 0;
        for (int i = 0; i < 210; i++) begin
            if (dropnp_log[i] === 1'b1) np_drops++;
            tx_log[i] = txnp_log[i];
        end
        decode(2, 5, v, bad);
        tests_run++;
        if (bad !== 0 || v[39:0] !== 40'h00_0000_0101 || np_drops !== 0) begin
            tests_failed++; $display("FAIL noparity_send: got %h errs %0d drops %0d want 0000000101,0,0", v[39:0], bad, np_drops);
        end
    endtask

    task automatic test_cts_stall();
        logic [71:0] v; int bad; int fz;
        cts = 1'b0;
        send(72'h00_A53C_0F80_00, 0, 0);
        capture(265, 50, 100, -1, -1);
        cts = 1'b1;
        fz = first_zero(0);
        tests_run++;
        if (fz !== 52) begin tests_failed++; $display("FAIL cts_start: got %0d want 52", fz); end
        decode(52, 5, v, bad);
        tests_run++;
        if (bad !== 0 || v[39:0] !== 40'hA53C_0F80_00) begin
            tests_failed++; $display("FAIL cts_midpacket: got %h (framing errs %0d) want a53c0f8000", v[39:0], bad);
        end
    endtask

    task automatic test_sync_idle();
        int so_len; int rdy_first;
        tests_run++;
        if (rdy !== 1'b1) begin tests_failed++; $display("FAIL sync_rdy_before: got %b want 1", rdy); end
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        capture(20, -1, -1, -1, -1);
        so_len = 0;
        for (int i = 0; i < 20 && so_log[i] === 1'b1; i++) so_len++;
        rdy_first = -1;
        for (int i = 19; i >= 0; i--) if (rdy_log[i] === 1'b1) rdy_first = i;
        tests_run++;
        if (tx_log[0] !== 1'b1 || low_run(1) !== 12 || tx_log[13] !== 1'b1) begin
            tests_failed++; $display("FAIL sync_break: got tx0=%b low=%0d tx13=%b want 1,12,1", tx_log[0], low_run(1), tx_log[13]);
        end
        tests_run++;
        if (so_len !== 12) begin tests_failed++; $display("FAIL sync_flag: got %0d cycles want 12", so_len); end
        tests_run++;
        if (rdy_first !== 13) begin tests_failed++; $display("FAIL sync_rdy: got first high %0d want 13", rdy_first); end
    endtask

    task automatic test_sync_with_transfer();
        logic [71:0] v; int bad; int fz;
        send(72'h00_A53C_0F80_00, 0, 1);
        capture(225, -1, -1, -1, -1);
        fz = first_zero(13);
        tests_run++;
        if (low_run(1) !== 12 || tx_log[13] !== 1'b1 || fz !== 14) begin
            tests_failed++; $display("FAIL simul_order: got low=%0d tx13=%b start=%0d want 12,1,14", low_run(1), tx_log[13], fz);
        end
        decode(14, 5, v, bad);
        tests_run++;
        if (bad !== 0 || v[39:0] !== 40'hA53C_0F80_00) begin
            tests_failed++; $display("FAIL simul_data: got %h (framing errs %0d) want a53c0f8000", v[39:0], bad);
        end
    endtask

    task automatic test_sync_long();
        logic [71:0] v; int bad;
        send(72'h0000_0005_0000_0005_02, 0, 0);
        capture(380, -1, -1, 100, 200);
        decode(2, 9, v, bad);
        tests_run++;
        if (bad !== 0 || v !== 72'h0000_0005_0000_0005_02) begin
            tests_failed++; $display("FAIL synclong_data: got %h (framing errs %0d) want 000000050000000502", v, bad);
        end
        tests_run++;
        if (so_log[100] !== 1'b0 || so_log[101] !== 1'b1 || so_log[372] !== 1'b1 || so_log[373] !== 1'b0) begin
            tests_failed++; $display("FAIL synclong_flag: got %b%b%b%b want 0110", so_log[100], so_log[101], so_log[372], so_log[373]);
        end
        tests_run++;
        if (low_run(362) !== 12 || count_tx_low(374, 379) !== 0) begin
            tests_failed++; $display("FAIL synclong_break: got low=%0d extra-low=%0d want 12,0", low_run(362), count_tx_low(374, 379));
        end
        tests_run++;
        if (rdy_log[373] !== 1'b0 || rdy_log[374] !== 1'b1) begin
            tests_failed++; $display("FAIL synclong_rdy: got %b%b want 01", rdy_log[373], rdy_log[374]);
        end
    endtask

    task automatic test_reset_midframe();
        send(72'h00_0000_0100, 0, 0);
        capture(21, -1, -1, -1, -1);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (tx !== 1'b1 || rdy !== 1'b0) begin
            tests_failed++; $display("FAIL async_reset: got tx=%b rdy=%b want 1,0", tx, rdy);
        end
        @(negedge clk);
        rst = 1'b0;
        capture(60, -1, -1, -1, -1);
        tests_run++;
        if (count_tx_low(0, 59) !== 0 || rdy_log[59] !== 1'b1) begin
            tests_failed++; $display("FAIL reset_lost_packet: got %0d low cycles rdy=%b want 0,1", count_tx_low(0, 59), rdy_log[59]);
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_bad_parity();
        test_cts_stall();
        repeat (5) @(negedge clk);
        test_sync_idle();
        repeat (3) @(negedge clk);
        test_sync_with_transfer();
        test_sync_long();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
